// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM sequencing a shared RV32-subset datapath (R, I-ALU, LW, SW, BEQ)
// over several cycles per instruction through a single unified memory port.
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   run             : 1 = fetch/execute, 0 = stop at next instruction boundary
//   instruction     : IR contents, only [6:0] are decoded
//   zero            : ALU zero flag (BEQ outcome)
//   mem_ready       : memory completes the current request this cycle
//   mem_req/mem_we  : memory request valid / write (1) or read (0)
//   addr_sel        : memory address source, 0 = PC, 1 = ALU result register
//   ir_write        : load IR and old_pc
//   pc_write/pc_src : load PC / source 0 = PC+4, 1 = old_pc+imm
//   alu_src/alu_op  : operand B select / 00 ADD, 01 SUB, 10 funct decode
//   reg_write/wb_sel: register write enable / source 0 = ALU, 1 = memory
//   retire          : pulse on the last cycle of every instruction
//   instret         : retired-instruction counter (wraps)
//   halted          : 1 while idle
//   trap            : sticky illegal-opcode flag, cleared only by rst_n
// -----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int INSTRSIZE = 32,
   parameter int CNTSIZE   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic [INSTRSIZE-1:0] instruction,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 addr_sel,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_src,
   output logic                 alu_src,
   output logic [1:0]           alu_op,
   output logic                 reg_write,
   output logic                 wb_sel,
   output logic                 retire,
   output logic [CNTSIZE-1:0]   instret,
   output logic                 halted,
   output logic                 trap
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_WB_ALU   = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_FUN = 2'b10;

   state_t               state_q, state_d;
   logic [6:0]           opcode_q, opcode_d;
   logic [CNTSIZE-1:0]   instret_q, instret_d;
   logic                 trap_q, trap_d;
   logic                 retire_s;

   // Only the opcode field is decoded; the rest of the IR belongs to the datapath.
   logic unused_instr_s;
   assign unused_instr_s = ^instruction[INSTRSIZE-1:7];

   // State, latched opcode, retire counter and sticky trap flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         opcode_q  <= 7'd0;
         instret_q <= '0;
         trap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         instret_q <= instret_d;
         trap_q    <= trap_d;
      end
   end

   // Next-state logic; run is only consulted in IDLE and on retire cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (run) state_d = S_FETCH; else state_d = S_IDLE;
         S_FETCH:    if (mem_ready) state_d = S_DECODE; else state_d = S_FETCH;
         S_DECODE: begin
            // Decode straight from the IR; the latched copy is not valid until next cycle.
            case (instruction[6:0])
               OP_R:          state_d = S_EXEC_R;
               OP_I:          state_d = S_EXEC_I;
               OP_LW, OP_SW:  state_d = S_MEM_ADDR;
               OP_BEQ:        state_d = S_BRANCH;
               default:       state_d = S_TRAP;
            endcase
         end
         S_EXEC_R:   state_d = S_WB_ALU;
         S_EXEC_I:   state_d = S_WB_ALU;
         S_MEM_ADDR: begin
            if (opcode_q == OP_LW)      state_d = S_MEM_RD;
            else if (opcode_q == OP_SW) state_d = S_MEM_WR;
            else                        state_d = S_TRAP;
         end
         S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM; else state_d = S_MEM_RD;
         S_MEM_WR: begin
            if (!mem_ready) state_d = S_MEM_WR;
            else if (run)   state_d = S_FETCH;
            else            state_d = S_IDLE;
         end
         S_WB_ALU, S_WB_MEM, S_BRANCH: begin
            if (run) state_d = S_FETCH; else state_d = S_IDLE;
         end
         S_TRAP:     state_d = S_TRAP;
         // Unreachable encodings are treated as a fault and parked in TRAP.
         default:    state_d = S_TRAP;
      endcase
   end

   // Control outputs: Moore decode of state, with ir_write/pc_write/retire qualified
   // by mem_ready or zero where the handshake or branch outcome requires it.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      alu_src   = 1'b0;
      alu_op    = ALU_ADD;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      retire_s  = 1'b0;
      halted    = 1'b0;
      case (state_q)
         S_IDLE:     halted = 1'b1;
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_EXEC_R:   alu_op = ALU_FUN;
         S_EXEC_I: begin
            alu_src = 1'b1;
            alu_op  = ALU_FUN;
         end
         S_WB_ALU: begin
            reg_write = 1'b1;
            retire_s  = 1'b1;
         end
         S_MEM_ADDR: alu_src = 1'b1;
         S_MEM_RD: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
         end
         S_WB_MEM: begin
            reg_write = 1'b1;
            wb_sel    = 1'b1;
            retire_s  = 1'b1;
         end
         S_MEM_WR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = 1'b1;
            retire_s = mem_ready;
         end
         S_BRANCH: begin
            alu_op   = ALU_SUB;
            retire_s = 1'b1;
            pc_write = zero;
            pc_src   = zero;
         end
         default: begin
            halted = 1'b0;
         end
      endcase
   end

   // Opcode capture, retire counting and sticky trap.
   always_comb begin
      if (state_q == S_DECODE) opcode_d = instruction[6:0];
      else                     opcode_d = opcode_q;
      if (retire_s) instret_d = instret_q + CNTSIZE'(1);
      else          instret_d = instret_q;
      trap_d = trap_q | (state_d == S_TRAP);
   end

   assign retire  = retire_s;
   assign instret = instret_q;
   assign trap    = trap_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // Expected-output bits: {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
   // alu_src, alu_op[1:0], reg_write, wb_sel, retire, halted, trap}
   localparam logic [13:0] E_REQ  = 14'h2000;
   localparam logic [13:0] E_WE   = 14'h1000;
   localparam logic [13:0] E_ASEL = 14'h0800;
   localparam logic [13:0] E_IRW  = 14'h0400;
   localparam logic [13:0] E_PCW  = 14'h0200;
   localparam logic [13:0] E_PCS  = 14'h0100;
   localparam logic [13:0] E_ASRC = 14'h0080;
   localparam logic [13:0] E_FUN  = 14'h0040;
   localparam logic [13:0] E_SUB  = 14'h0020;
   localparam logic [13:0] E_RW   = 14'h0010;
   localparam logic [13:0] E_WBS  = 14'h0008;
   localparam logic [13:0] E_RET  = 14'h0004;
   localparam logic [13:0] E_HLT  = 14'h0002;
   localparam logic [13:0] E_TRP  = 14'h0001;

   logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
   logic [31:0] instruction = 32'd0;

   logic mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src;
   logic reg_write, wb_sel, retire, halted, trap;
   logic [1:0]  alu_op;
   logic [31:0] instret;
   logic mem_req4, mem_we4, addr_sel4, ir_write4, pc_write4, pc_src4, alu_src4;
   logic reg_write4, wb_sel4, retire4, halted4, trap4;
   logic [1:0]  alu_op4;
   logic [3:0]  instret4;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model_cnt = 32'd0;
   bit          run_noise = 1'b1;

   logic [13:0] exp_q[$];
   bit          rdy_q[$], z_q[$], run_q[$];
   logic [31:0] ins_q[$];
   logic [13:0] act_q[$], act4_q[$];
   logic [31:0] cnt_q[$];
   logic [3:0]  cnt4_q[$];

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
      .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
      .instret(instret), .halted(halted), .trap(trap)
   );

   multicycle_controller #(.INSTRSIZE(32), .CNTSIZE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req4), .mem_we(mem_we4), .addr_sel(addr_sel4),
      .ir_write(ir_write4), .pc_write(pc_write4), .pc_src(pc_src4), .alu_src(alu_src4),
      .alu_op(alu_op4), .reg_write(reg_write4), .wb_sel(wb_sel4), .retire(retire4),
      .instret(instret4), .halted(halted4), .trap(trap4)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] outv();
      return {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src, alu_op,
              reg_write, wb_sel, retire, halted, trap};
   endfunction

   function automatic logic [13:0] outv4();
      return {mem_req4, mem_we4, addr_sel4, ir_write4, pc_write4, pc_src4, alu_src4, alu_op4,
              reg_write4, wb_sel4, retire4, halted4, trap4};
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // run value for cycles where the controller must ignore it
   function automatic bit rnf();
      return run_noise ? rb() : 1'b0;
   endfunction

   function automatic logic [31:0] rins(input logic [6:0] op);
      logic [31:0] r;
      r = $urandom();
      return {r[31:7], op};
   endfunction

   task automatic clear_q();
      exp_q.delete(); rdy_q.delete(); z_q.delete(); run_q.delete(); ins_q.delete();
   endtask

   task automatic push(input logic [13:0] e, input bit r, input bit z, input bit rn,
                       input logic [31:0] ins);
      exp_q.push_back(e); rdy_q.push_back(r); z_q.push_back(z);
      run_q.push_back(rn); ins_q.push_back(ins);
   endtask

   task automatic push_idle(input bit rn);
      push(E_HLT, rb(), rb(), rn, $urandom());
   endtask

   // Reference model: per-opcode cycle script derived from the instruction's phases.
   task automatic build_instr(input logic [31:0] ins, input int fw, input int mw,
                              input bit z, input bit run_end);
      logic [31:0] junk;
      for (int k = 0; k < fw; k++) push(E_REQ, 1'b0, rb(), rnf(), ins);
      push(E_REQ | E_IRW | E_PCW, 1'b1, rb(), rnf(), ins);
      push(14'h0000, rb(), rb(), rnf(), ins);
      junk = $urandom();   // IR may change after decode; opcode must stay latched
      case (ins[6:0])
         OP_R: begin
            push(E_FUN, rb(), rb(), rnf(), junk);
            push(E_RW | E_RET, rb(), rb(), run_end, junk);
         end
         OP_I: begin
            push(E_ASRC | E_FUN, rb(), rb(), rnf(), junk);
            push(E_RW | E_RET, rb(), rb(), run_end, junk);
         end
         OP_LW: begin
            push(E_ASRC, rb(), rb(), rnf(), junk);
            for (int k = 0; k < mw; k++) push(E_REQ | E_ASEL, 1'b0, rb(), rnf(), junk);
            push(E_REQ | E_ASEL, 1'b1, rb(), rnf(), junk);
            push(E_RW | E_WBS | E_RET, rb(), rb(), run_end, junk);
         end
         OP_SW: begin
            push(E_ASRC, rb(), rb(), rnf(), junk);
            for (int k = 0; k < mw; k++) push(E_REQ | E_WE | E_ASEL, 1'b0, rb(), rnf(), junk);
            push(E_REQ | E_WE | E_ASEL | E_RET, 1'b1, rb(), run_end, junk);
         end
         OP_BEQ: push(E_SUB | E_RET | (z ? (E_PCW | E_PCS) : 14'h0000), rb(), z, run_end, junk);
         default: for (int k = 0; k < 20; k++) push(E_TRP, rb(), rb(), rb(), junk);
      endcase
   endtask

   // Apply the scripted inputs one cycle at a time and record both DUTs' outputs.
   task automatic play();
      act_q.delete(); act4_q.delete(); cnt_q.delete(); cnt4_q.delete();
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         run = run_q[i]; mem_ready = rdy_q[i]; zero = z_q[i]; instruction = ins_q[i];
         #1;
         act_q.push_back(outv()); act4_q.push_back(outv4());
         cnt_q.push_back(instret); cnt4_q.push_back(instret4);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({outv(), outv4(), instret, instret4} !== {E_HLT, E_HLT, 32'd0, 4'd0}) begin
         miscompares++;
         $display("FAIL reset: got %h/%h/%0d/%0d want %h/%h/0/0",
                  outv(), outv4(), instret, instret4, E_HLT, E_HLT);
      end
      model_cnt = 32'd0;
      @(negedge clk); rst_n = 1'b1;
      clear_q();
      push_idle(1'b0); push_idle(1'b0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if ({act_q[i], act4_q[i], cnt_q[i], cnt4_q[i]} !== {exp_q[i], exp_q[i], model_cnt, model_cnt[3:0]}) begin
            miscompares++;
            $display("FAIL idle cycle %0d: got %h/%h/%0d/%0d want %h/%0d", i, act_q[i], act4_q[i], cnt_q[i], cnt4_q[i], exp_q[i], model_cnt);
         end
         if (exp_q[i][2]) model_cnt++;
      end
   endtask

   task automatic test_alu();
      clear_q();
      push_idle(1'b1);
      build_instr(32'h00208033, 0, 0, 1'b0, 1'b1);
      for (int n = 0; n < 8; n++)
         build_instr(rins(rb() ? OP_R : OP_I), $urandom_range(0, 3), 0, 1'b0, n != 7);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if ({act_q[i], act4_q[i], cnt_q[i], cnt4_q[i]} !== {exp_q[i], exp_q[i], model_cnt, model_cnt[3:0]}) begin
            miscompares++;
            $display("FAIL alu cycle %0d: got %h/%h/%0d/%0d want %h/%0d", i, act_q[i], act4_q[i], cnt_q[i], cnt4_q[i], exp_q[i], model_cnt);
         end
         if (exp_q[i][2]) model_cnt++;
      end
   endtask

   task automatic test_load_store();
      clear_q();
      push_idle(1'b1);
      build_instr(32'h0000A103, 2, 3, 1'b0, 1'b1);
      for (int n = 0; n < 8; n++)
         build_instr(rins(rb() ? OP_LW : OP_SW), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'b0, n != 7);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if ({act_q[i], act4_q[i], cnt_q[i], cnt4_q[i]} !== {exp_q[i], exp_q[i], model_cnt, model_cnt[3:0]}) begin
            miscompares++;
            $display("FAIL ldst cycle %0d: got %h/%h/%0d/%0d want %h/%0d", i, act_q[i], act4_q[i], cnt_q[i], cnt4_q[i], exp_q[i], model_cnt);
         end
         if (exp_q[i][2]) model_cnt++;
      end
   endtask

   task automatic test_branch();
      clear_q();
      push_idle(1'b1);
      build_instr(32'h00000463, 0, 0, 1'b1, 1'b1);
      build_instr(32'h00000463, 0, 0, 1'b0, 1'b1);
      for (int n = 0; n < 6; n++)
         build_instr(rins(OP_BEQ), $urandom_range(0, 2), 0, rb(), n != 5);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if ({act_q[i], act4_q[i], cnt_q[i], cnt4_q[i]} !== {exp_q[i], exp_q[i], model_cnt, model_cnt[3:0]}) begin
            miscompares++;
            $display("FAIL branch cycle %0d: got %h/%h/%0d/%0d want %h/%0d", i, act_q[i], act4_q[i], cnt_q[i], cnt4_q[i], exp_q[i], model_cnt);
         end
         if (exp_q[i][2]) model_cnt++;
      end
   endtask

   task automatic test_run_stop();
      clear_q();
      run_noise = 1'b0;   // run held low from FETCH on, including EXEC_I
      push_idle(1'b1);
      build_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) push_idle(1'b0);
      push_idle(1'b1);
      build_instr(32'h00500093, 1, 0, 1'b0, 1'b0);
      run_noise = 1'b1;
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if ({act_q[i], act4_q[i], cnt_q[i], cnt4_q[i]} !== {exp_q[i], exp_q[i], model_cnt, model_cnt[3:0]}) begin
            miscompares++;
            $display("FAIL runstop cycle %0d: got %h/%h/%0d/%0d want %h/%0d", i, act_q[i], act4_q[i], cnt_q[i], cnt4_q[i], exp_q[i], model_cnt);
         end
         if (exp_q[i][2]) model_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      test_reset();
      clear_q();
      push_idle(1'b1);
      for (int n = 0; n < 17; n++) build_instr(rins(OP_I), 0, 0, 1'b0, n != 16);
      push_idle(1'b0);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if ({act_q[i], act4_q[i], cnt_q[i], cnt4_q[i]} !== {exp_q[i], exp_q[i], model_cnt, model_cnt[3:0]}) begin
            miscompares++;
            $display("FAIL b2b cycle %0d: got %h/%h/%0d/%0d want %h/%0d", i, act_q[i], act4_q[i], cnt_q[i], cnt4_q[i], exp_q[i], model_cnt);
         end
         if (exp_q[i][2]) model_cnt++;
      end
   endtask

   task automatic test_trap();
      logic [6:0] ops [2];
      ops[0] = 7'h7F;
      ops[1] = 7'h6F;
      for (int t = 0; t < 2; t++) begin
         clear_q();
         push_idle(1'b1);
         build_instr(rins(OP_R), 0, 0, 1'b0, 1'b1);
         build_instr((t == 0) ? 32'h0000007F : rins(ops[t]), $urandom_range(0, 2), 0, 1'b0, 1'b1);
         play();
         for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if ({act_q[i], act4_q[i], cnt_q[i], cnt4_q[i]} !== {exp_q[i], exp_q[i], model_cnt, model_cnt[3:0]}) begin
               miscompares++;
               $display("FAIL trap%0d cycle %0d: got %h/%h/%0d/%0d want %h/%0d", t, i, act_q[i], act4_q[i], cnt_q[i], cnt4_q[i], exp_q[i], model_cnt);
            end
            if (exp_q[i][2]) model_cnt++;
         end
         rst_n = 1'b0;
         #1;
         vectors++;
         if ({outv(), outv4(), instret, instret4} !== {E_HLT, E_HLT, 32'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL trap%0d_reset: got %h/%h/%0d/%0d want %h/%h/0/0", t, outv(), outv4(), instret, instret4, E_HLT, E_HLT);
         end
         model_cnt = 32'd0;
         run = 1'b0;
         @(negedge clk); rst_n = 1'b1;
      end
   endtask

   task automatic test_reset_mid_store();
      clear_q();
      push_idle(1'b1);
      build_instr(rins(OP_I), 0, 0, 1'b0, 1'b1);
      build_instr(rins(OP_R), 0, 0, 1'b0, 1'b1);
      build_instr(rins(OP_SW), 1, 5, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin   // stop two cycles into the MEM_WR wait
         void'(exp_q.pop_back()); void'(rdy_q.pop_back()); void'(z_q.pop_back());
         void'(run_q.pop_back()); void'(ins_q.pop_back());
      end
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if ({act_q[i], act4_q[i], cnt_q[i], cnt4_q[i]} !== {exp_q[i], exp_q[i], model_cnt, model_cnt[3:0]}) begin
            miscompares++;
            $display("FAIL midstore cycle %0d: got %h/%h/%0d/%0d want %h/%0d", i, act_q[i], act4_q[i], cnt_q[i], cnt4_q[i], exp_q[i], model_cnt);
         end
         if (exp_q[i][2]) model_cnt++;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({outv(), outv4(), instret, instret4} !== {E_HLT, E_HLT, 32'd0, 4'd0}) begin
         miscompares++;
         $display("FAIL midstore_reset: got %h/%h/%0d/%0d want %h/%h/0/0", outv(), outv4(), instret, instret4, E_HLT, E_HLT);
      end
      model_cnt = 32'd0;
      run = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_branch();
      test_run_stop();
      test_back_to_back();
      test_trap();
      test_reset_mid_store();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
